// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: sequences a multi-cycle multiply/divide that sits beside
// the execute stage. It spots a mult/div in X, latches its operands, fires a
// one-cycle start pulse at the multdiv unit, stalls the front of the pipeline
// until the unit answers (or a timeout expires) and then performs exactly one
// register-file writeback: the result to rd, or an exception code to rstatus.
//
// Handshake with the multdiv unit: md_ctrl_mult/md_ctrl_div is a single-cycle
// start strobe raised only in START; md_opA/md_opB are stable from that cycle
// until the next detected mult/div. md_rdy is a single-cycle completion strobe
// that qualifies md_result and md_exception. It is honoured only in BUSY and is
// ignored in any other state (including after a flush has aborted the op).
module multdiv_sequencer #(
    parameter int TIMEOUT       = 40,
    parameter int CNT_W         = 6,
    parameter int RSTATUS_REG   = 30,
    parameter int MULT_EXC_CODE = 4,
    parameter int DIV_EXC_CODE  = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [4:0]  ex_opcode,
    input  logic [4:0]  ex_aluop,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_opA,
    input  logic [31:0] ex_opB,
    input  logic        flush,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_rdy,
    output logic        stall,
    output logic        busy,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [4:0]       ALUOP_MULT = 5'd6;
    localparam logic [4:0]       ALUOP_DIV  = 5'd7;
    localparam logic [4:0]       RST_REG    = 5'(RSTATUS_REG);
    localparam logic [31:0]      MULT_CODE  = 32'(MULT_EXC_CODE);
    localparam logic [31:0]      DIV_CODE   = 32'(DIV_EXC_CODE);

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [31:0]       opa_q,    opa_d;
    logic [31:0]       opb_q,    opb_d;
    logic [4:0]        rd_q,     rd_d;
    logic              is_div_q, is_div_d;
    logic              exc_q,    exc_d;
    logic [31:0]       result_q, result_d;

    logic              det;

    // A real, unsquashed mult or div sitting in X.
    assign det = ex_valid & ~flush & (ex_opcode == 5'd0) &
                 ((ex_aluop == ALUOP_MULT) | (ex_aluop == ALUOP_DIV));

    // State and operation latches; reset aborts any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rd_q     <= '0;
            is_div_q <= 1'b0;
            exc_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rd_q     <= rd_d;
            is_div_q <= is_div_d;
            exc_q    <= exc_d;
            result_q <= result_d;
        end
    end

    // Next-state logic: detect, launch, wait for ready/timeout/flush, write back.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rd_d     = rd_q;
        is_div_d = is_div_q;
        exc_d    = exc_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (det) begin
                    opa_d    = ex_opA;
                    opb_d    = ex_opB;
                    rd_d     = ex_rd;
                    is_div_d = ex_aluop[0];
                    exc_d    = 1'b0;
                    result_d = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                // md_rdy cannot be meaningful yet; the unit was only just started.
                cnt_d   = '0;
                state_d = flush ? S_IDLE : S_BUSY;
            end
            S_BUSY: begin
                cnt_d = cnt_q + CNT_ONE;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (md_rdy) begin
                    // A ready result beats a timeout landing on the same cycle.
                    result_d = md_result;
                    exc_d    = md_exception;
                    state_d  = S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    exc_d   = 1'b1;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // The same instruction is still in X here; do not re-detect it.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state and latched operation data.
    always_comb begin
        stall        = 1'b0;
        busy         = 1'b0;
        md_ctrl_mult = 1'b0;
        md_ctrl_div  = 1'b0;
        wb_we        = 1'b0;
        wb_reg       = '0;
        wb_data      = '0;
        unique case (state_q)
            S_IDLE: begin
                stall = det & ~reset;
            end
            S_START: begin
                stall        = 1'b1;
                busy         = 1'b1;
                md_ctrl_mult = ~is_div_q;
                md_ctrl_div  = is_div_q;
            end
            S_BUSY: begin
                stall = 1'b1;
                busy  = 1'b1;
            end
            S_WB: begin
                busy = 1'b1;
                if (exc_q) begin
                    wb_we   = 1'b1;
                    wb_reg  = RST_REG;
                    wb_data = is_div_q ? DIV_CODE : MULT_CODE;
                end else begin
                    wb_we   = (rd_q != 5'd0);
                    wb_reg  = rd_q;
                    wb_data = result_q;
                end
            end
            default: ;
        endcase
    end

    assign md_opA    = opa_q;
    assign md_opB    = opb_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: directed scenarios plus randomized mult/div
// transactions, each checked cycle by cycle against a transaction-level model
// that predicts stall/busy/pulse/writeback timing from the detect cycle.
module tb_multdiv_sequencer;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic [4:0]  ex_aluop;
  logic [4:0]  ex_rd;
  logic [31:0] ex_opA;
  logic [31:0] ex_opB;
  logic        flush;
  logic [31:0] md_opA;
  logic [31:0] md_opB;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_rdy;
  logic        stall;
  logic        busy;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 clock = ~clock;

  multdiv_sequencer #(
    .TIMEOUT(TIMEOUT), .CNT_W(6), .RSTATUS_REG(30),
    .MULT_EXC_CODE(4), .DIV_EXC_CODE(5)
  ) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_aluop(ex_aluop),
    .ex_rd(ex_rd), .ex_opA(ex_opA), .ex_opB(ex_opB), .flush(flush),
    .md_opA(md_opA), .md_opB(md_opB),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_result(md_result), .md_exception(md_exception), .md_rdy(md_rdy),
    .stall(stall), .busy(busy),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic drive_bubble();
    ex_valid     = 1'b0;
    ex_opcode    = 5'($urandom_range(0, 31));
    ex_aluop     = 5'($urandom_range(0, 31));
    ex_rd        = 5'($urandom_range(0, 31));
    ex_opA       = $urandom;
    ex_opB       = $urandom;
    flush        = 1'b0;
    md_rdy       = 1'b0;
    md_result    = $urandom;
    md_exception = 1'($urandom_range(0, 1));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pulse"}, {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    check({tag, "_we"}, 32'(wb_we), 32'd0);
  endtask

  // One mult/div transaction. rdy_cyc: cycle of md_rdy relative to the detect
  // cycle (values < 2 mean it never arrives). fl_cyc: flush cycle (0 = none).
  task automatic run_op(input bit is_div, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input bit exc,
                        input int rdy_cyc, input int fl_cyc);
    int done_cyc, wb_cyc, last;
    bit timed_out, e_exc, held;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    timed_out = !(rdy_cyc >= 2 && rdy_cyc <= TIMEOUT + 1);
    if (fl_cyc > 0) begin
      done_cyc = fl_cyc;
      wb_cyc   = -1;
      last     = (rdy_cyc > fl_cyc) ? rdy_cyc + 1 : fl_cyc + 1;
    end else begin
      done_cyc = timed_out ? TIMEOUT + 1 : rdy_cyc;
      wb_cyc   = done_cyc + 1;
      last     = wb_cyc;
    end
    e_exc = timed_out ? 1'b1 : exc;
    if (e_exc) begin
      e_we = 1'b1; e_reg = 5'd30; e_data = is_div ? 32'd5 : 32'd4;
    end else begin
      e_we = (rd != 5'd0); e_reg = rd; e_data = res;
    end
    for (int c = 0; c <= last; c++) begin
      @(posedge clock); #1;
      drive_bubble();
      held = (c <= done_cyc) || (c == wb_cyc);
      if (held) begin
        ex_valid  = 1'b1;
        ex_opcode = 5'd0;
        ex_aluop  = is_div ? 5'd7 : 5'd6;
        ex_rd     = rd;
        ex_opA    = a;
        ex_opB    = b;
      end
      flush = (fl_cyc > 0) && (c == fl_cyc);
      if (rdy_cyc >= 2 && c == rdy_cyc) begin
        md_rdy       = 1'b1;
        md_result    = res;
        md_exception = exc;
      end
      #1;
      check("stall", 32'(stall), 32'(c <= done_cyc));
      check("busy", 32'(busy), 32'(c >= 1 && (c <= done_cyc || c == wb_cyc)));
      check("pulse_mult", 32'(md_ctrl_mult), 32'(c == 1 && !is_div));
      check("pulse_div", 32'(md_ctrl_div), 32'(c == 1 && is_div));
      if (c == wb_cyc) begin
        check("wb_we", 32'(wb_we), 32'(e_we));
        check("wb_reg", 32'(wb_reg), 32'(e_reg));
        check("wb_data", wb_data, e_data);
      end else begin
        check("no_we", 32'(wb_we), 32'd0);
        check("no_reg", 32'(wb_reg), 32'd0);
        check("no_data", wb_data, 32'd0);
      end
      if (c >= 1) begin
        check("md_opA", md_opA, a);
        check("md_opB", md_opB, b);
      end
    end
  endtask

  // Instructions that must not start anything.
  task automatic run_noop(input bit valid, input logic [4:0] opc,
                          input logic [4:0] aluop, input bit fl);
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      drive_bubble();
      ex_valid  = valid;
      ex_opcode = opc;
      ex_aluop  = aluop;
      flush     = fl;
      #1;
      check_quiet("noop");
    end
  endtask

  // Reset asserted in the middle of a mult: outputs clear at once, no write follows.
  task automatic run_reset_mid();
    for (int c = 0; c <= 5; c++) begin
      @(posedge clock); #1;
      drive_bubble();
      ex_valid = 1'b1; ex_opcode = 5'd0; ex_aluop = 5'd6; ex_rd = 5'd9;
      ex_opA = 32'h1234; ex_opB = 32'h5678;
      #1;
      check("rst_pre_stall", 32'(stall), 32'd1);
    end
    #2 reset = 1'b1;
    #1;
    check_quiet("rst_async");
    check("rst_opA", md_opA, 32'd0);
    check("rst_opB", md_opB, 32'd0);
    check("rst_reg", 32'(wb_reg), 32'd0);
    check("rst_data", wb_data, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    drive_bubble();
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      drive_bubble();
      md_rdy = (c == 1);
      #1;
      check_quiet("rst_after");
    end
  endtask

  initial begin
    drive_bubble();
    reset = 1'b1;
    #1;
    check_quiet("reset");
    check("reset_opA", md_opA, 32'd0);
    check("reset_reg", 32'(wb_reg), 32'd0);
    check("reset_data", wb_data, 32'd0);
    #22 reset = 1'b0;

    // directed scenarios
    run_op(1'b0, 5'd5, 32'd6, 32'd7, 32'd42, 1'b0, 20, 0);
    run_op(1'b1, 5'd3, 32'd9, 32'd0, 32'd0, 1'b1, 35, 0);
    run_op(1'b0, 5'd7, 32'd11, 32'd12, 32'd0, 1'b0, 0, 0);
    run_op(1'b1, 5'd8, 32'd100, 32'd3, 32'd0, 1'b0, 0, 0);
    run_op(1'b0, 5'd0, 32'd2, 32'd3, 32'd6, 1'b0, 20, 0);
    run_noop(1'b1, 5'd0, 5'd0, 1'b0);
    run_noop(1'b0, 5'd0, 5'd6, 1'b0);
    run_noop(1'b1, 5'd0, 5'd7, 1'b1);
    run_noop(1'b1, 5'd1, 5'd6, 1'b0);
    run_op(1'b0, 5'd4, 32'd5, 32'd5, 32'd25, 1'b0, 16, 11);
    run_op(1'b1, 5'd4, 32'd5, 32'd5, 32'd1, 1'b0, 9, 1);
    run_reset_mid();
    run_op(1'b0, 5'd6, 32'd3, 32'd4, 32'd12, 1'b0, TIMEOUT + 1, 0);
    run_op(1'b0, 5'd10, 32'd1, 32'd2, 32'd2, 1'b0, 2, 0);
    run_op(1'b0, 5'd11, 32'd3, 32'd3, 32'd9, 1'b0, 4, 0);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      bit is_div, exc;
      int rdy, fl, nom;
      is_div = 1'($urandom_range(0, 1));
      exc    = ($urandom_range(0, 3) == 0);
      rdy    = $urandom_range(2, TIMEOUT + 4);
      nom    = (rdy <= TIMEOUT + 1) ? rdy : TIMEOUT + 1;
      fl     = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nom) : 0;
      run_op(is_div, 5'($urandom_range(0, 31)), $urandom, $urandom,
             $urandom, exc, rdy, fl);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock); #1;
        drive_bubble();
        #1;
        check_quiet("gap");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
